uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receiver: receiver state encoding,
//   parity-mode constants and the clock-cycles-per-baud helper.
//   Configuration macro: UART_RX_PARITY_EN (adds the PARITY state when defined).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } rx_state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Integer number of clock cycles spanned by one bit on the line.
   function automatic int cycles_per_baud(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchroniser for a single asynchronous input.
//   Ports:
//     clk_in  - clock
//     rst_in  - asynchronous active-high reset (flops load RST_VAL)
//     d_in    - asynchronous input
//     q_out   - synchronised output
// -----------------------------------------------------------------------------
module uart_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_in,
   output logic q_out
);

   logic [1:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, independent of block order.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_q <= {2{RST_VAL}};
      end else begin
         sync_q <= {sync_q[0], d_in};
      end
   end

   assign q_out = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Configurable UART receiver with 3-sample majority voting, framing check,
//   optional parity check and a valid/ready output holding register.
//   Configuration macro: UART_RX_PARITY_EN -- builds the PARITY state and the
//   parity check selected by PARITY; otherwise parity_err_out is tied low.
//   Ports:
//     clk_in         - clock, all state on rising edge
//     rst_in         - asynchronous active-high reset
//     uart_rx_in     - serial line, idle high, LSB first
//     data_out       - received payload, stable while valid_out is high
//     valid_out      - payload available
//     ready_in       - consumer accepts payload
//     frame_err_out  - a stop bit was sampled low (qualified by valid_out)
//     parity_err_out - parity mismatch (qualified by valid_out)
//     overrun_out    - one-cycle pulse, a completed frame was dropped
// -----------------------------------------------------------------------------
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 12_000_000,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 uart_rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 frame_err_out,
   output logic                 parity_err_out,
   output logic                 overrun_out
);

   localparam int CPB   = cycles_per_baud(CLK_FREQ, BAUD_RATE);
   localparam int H     = CPB / 2;
   localparam int CNT_W = $clog2(CPB);
   localparam int IDX_W = $clog2(DATA_BITS);

   if (CPB < 6) begin : g_bad_baud
      $error("uart_rx_cfg: CLK_FREQ/BAUD_RATE must be at least 6");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
   end
   if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
   end

   logic rx_sync;

   // Reset value 0: a line held low across reset release looks like "no
   // high seen yet", so no falling edge can be detected until it goes high.
   uart_sync #(.RST_VAL(1'b0)) u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d_in   (uart_rx_in),
      .q_out  (rx_sync)
   );

   rx_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           samp_q, samp_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 ferr_acc_q, ferr_acc_d;
   logic                 rx_prev_q, rx_prev_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 ovr_q, ovr_d;
   logic                 perr_acc_q, perr_acc_d;
   logic                 perr_q, perr_d;

   logic wrap, decide, bit_val, done;

   assign wrap    = (cnt_q == CNT_W'(CPB - 1));
   assign decide  = (cnt_q == CNT_W'(H + 1));
   // Majority of the samples at H-1, H (stored) and H+1 (live).
   assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      samp_d     = samp_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      ferr_acc_d = ferr_acc_q;
      perr_acc_d = perr_acc_q;
      rx_prev_d  = rx_sync;
      done       = 1'b0;

      if (cnt_q == CNT_W'(H - 1)) samp_d[0] = rx_sync;
      if (cnt_q == CNT_W'(H))     samp_d[1] = rx_sync;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_sync) begin
               state_d    = ST_START;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               ferr_acc_d = 1'b0;
               perr_acc_d = 1'b0;
            end
         end
         ST_START: begin
            if (decide && bit_val) begin
               state_d = ST_IDLE;    // start bit did not hold: glitch
               cnt_d   = '0;
            end else if (wrap) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (decide) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            if (wrap) begin
               if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                  bit_idx_d = '0;
                  state_d   = ST_STOP;
`ifdef UART_RX_PARITY_EN
                  if (PARITY != PARITY_NONE) state_d = ST_PARITY;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (decide) begin
               perr_acc_d = (PARITY == PARITY_ODD) ? ~(^{shift_q, bit_val})
                                                   :  (^{shift_q, bit_val});
            end
            if (wrap) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (decide) begin
               ferr_acc_d = ferr_acc_q | ~bit_val;
               if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                  // Last stop bit: finish now so a new start bit arriving
                  // right after the nominal stop is not missed.
                  done    = 1'b1;
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            if (wrap) stop_idx_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Output holding register.
      data_d  = data_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      ovr_d   = 1'b0;
      if (valid_q && ready_in) valid_d = 1'b0;
      if (done) begin
         if (!valid_q || ready_in) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ferr_acc_d;
            perr_d  = perr_acc_q;
         end else begin
            ovr_d = 1'b1;            // held payload wins, new frame dropped
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         samp_q     <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         ferr_acc_q <= 1'b0;
         perr_acc_q <= 1'b0;
         rx_prev_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         samp_q     <= samp_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         ferr_acc_q <= ferr_acc_d;
         perr_acc_q <= perr_acc_d;
         rx_prev_q  <= rx_prev_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign data_out      = data_q;
   assign valid_out     = valid_q;
   assign frame_err_out = ferr_q;
   assign overrun_out   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err_out = perr_q;
`else
   assign parity_err_out = 1'b0;
`endif

endmodule
